// File: rtl/interrupt_controller.sv
// interrupt_controller
// Collects level-sensitive requests from the bus peripherals, masks and
// prioritises them (source 0 highest), raises a single interrupt line to the
// processor and runs the acknowledge / end-of-interrupt handshake. The ID,
// mask, pending and EOI registers sit on the shared memory-mapped bus.
module interrupt_controller #(
  parameter int BITS    = 32,
  parameter int NUM_SRC = 4,
  parameter logic [BITS-1:0] ID_BASE   = 32'hF0000100,
  parameter logic [BITS-1:0] MASK_BASE = 32'hF0000104,
  parameter logic [BITS-1:0] PEND_BASE = 32'hF0000108,
  parameter logic [BITS-1:0] EOI_BASE  = 32'hF000010C
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  output logic [BITS-1:0]    dataBusOut,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic               intAck,
  output logic               intr,
  output logic [BITS-1:0]    debug
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Marker held in inService when no valid source has been acknowledged.
  localparam logic [7:0] SPURIOUS_ID = 8'hFF;

  state_t               r_state;
  state_t               w_nextState;
  logic [NUM_SRC-1:0]   r_irqSync;
  logic [NUM_SRC-1:0]   r_mask;
  logic [7:0]           r_inService;

  logic [NUM_SRC-1:0]   w_active;
  logic                 w_anyActive;
  logic [7:0]           w_lowIdx;
  logic                 w_maskWrite;
  logic                 w_eoiWrite;
  logic                 w_readEn;
  logic                 w_ackTaken;
  logic [1:0]           w_stateBits;
  logic                 w_unusedDataBits;

  assign w_active    = r_irqSync & r_mask;
  assign w_anyActive = |w_active;
  assign w_maskWrite = we && (memAddr == MASK_BASE);
  assign w_eoiWrite  = we && (memAddr == EOI_BASE);
  assign w_readEn    = re && !we;
  assign w_ackTaken  = (r_state == PENDING) && intAck;
  assign w_stateBits = r_state;

  // Mask bits above NUM_SRC carry no meaning; fold them into a sink.
  assign w_unusedDataBits = ^dataBusIn[BITS-1:NUM_SRC];

  // Priority encoder: lowest-numbered active source wins; nothing active
  // yields the spurious marker so an ack on a withdrawn request is visible.
  always_comb begin
    w_lowIdx = SPURIOUS_ID;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_lowIdx = 8'(i);
      end
    end
  end

  // Request synchroniser: one register stage on the level inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqSync <= '0;
    end else begin
      r_irqSync <= irqIn;
    end
  end

  // Mask register; an ack in the same cycle still sees the old mask since
  // the active vector is built from the registered value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_maskWrite) begin
      r_mask <= dataBusIn[NUM_SRC-1:0];
    end
  end

  // In-service ID is captured only when the processor acknowledges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inService <= SPURIOUS_ID;
    end else if (w_ackTaken) begin
      r_inService <= w_lowIdx;
    end
  end

  // State register for the request / acknowledge / EOI handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; acks are only meaningful while PENDING, and EOI only
  // while in SERVICE, so EOI naturally wins over a stray ack there.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_anyActive) begin
          w_nextState = PENDING;
        end
      end
      PENDING: begin
        if (intAck) begin
          w_nextState = SERVICE;
        end else if (!w_anyActive) begin
          w_nextState = IDLE;
        end
      end
      SERVICE: begin
        if (w_eoiWrite) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Interrupt line and debug view come straight from registers so reset
  // clears them without waiting for a clock edge.
  always_comb begin
    intr  = (r_state == PENDING);
    debug = '0;
    debug[7:0] = r_inService;
    debug[9:8] = w_stateBits;
  end

  // Combinational register reads; the bus expects data in the same cycle
  // as the address and zero whenever this block is not addressed.
  always_comb begin
    dataBusOut = '0;
    if (w_readEn) begin
      if (memAddr == ID_BASE) begin
        if ((r_state == SERVICE) && (r_inService != SPURIOUS_ID)) begin
          dataBusOut[7:0] = r_inService;
        end else begin
          dataBusOut = '1;
        end
      end else if (memAddr == MASK_BASE) begin
        dataBusOut[NUM_SRC-1:0] = r_mask;
      end else if (memAddr == PEND_BASE) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          dataBusOut[i] = w_active[i];
          if (16 + i < BITS) begin
            dataBusOut[16 + i] = r_irqSync[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
// Directed scenarios for the interrupt controller: reset state, masking,
// the ack / EOI handshake, withdrawal, spurious acks, simultaneous mask
// write and ack, asynchronous reset mid-service and ignored events in IDLE.
module tb_interrupt_controller;

  localparam logic [31:0] ID_ADDR   = 32'hF0000100;
  localparam logic [31:0] MASK_ADDR = 32'hF0000104;
  localparam logic [31:0] PEND_ADDR = 32'hF0000108;
  localparam logic [31:0] EOI_ADDR  = 32'hF000010C;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] memAddr;
  logic [31:0] dataBusIn;
  logic [31:0] dataBusOut;
  logic [3:0]  irqIn;
  logic        intAck;
  logic        intr;
  logic [31:0] debug;

  int assertCount;
  int failCount;
  logic [31:0] rdData;

  interrupt_controller #(
    .BITS(32),
    .NUM_SRC(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .re(re),
    .memAddr(memAddr),
    .dataBusIn(dataBusIn),
    .dataBusOut(dataBusOut),
    .irqIn(irqIn),
    .intAck(intAck),
    .intr(intr),
    .debug(debug)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Single-cycle bus write launched at a falling edge.
  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    memAddr = addr;
    dataBusIn = data;
    @(negedge clk);
    we = 1'b0;
    memAddr = '0;
    dataBusIn = '0;
  endtask

  // Combinational read sampled 1 ns after the address is presented.
  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    re = 1'b1;
    memAddr = addr;
    #1;
    data = dataBusOut;
    re = 1'b0;
    memAddr = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_intr: got %0b expected 0", intr);
    end
    assertCount++;
    if (debug !== 32'h000000FF) begin
      failCount++;
      $display("[TB] FAIL reset_debug: got %h expected 000000ff", debug);
    end
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'hFFFFFFFF) begin
      failCount++;
      $display("[TB] FAIL reset_id: got %h expected ffffffff", rdData);
    end
    busRead(32'h00001000, rdData);
    assertCount++;
    if (rdData !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL unaddressed_read: got %h expected 00000000", rdData);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_masked;
    irqIn = 4'b0010;
    tick(3);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL masked_intr: got %0b expected 0", intr);
    end
    busRead(PEND_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00020000) begin
      failCount++;
      $display("[TB] FAIL masked_pend: got %h expected 00020000", rdData);
    end
    // Read strobe together with write strobe must not drive the bus.
    re = 1'b1;
    we = 1'b1;
    memAddr = PEND_ADDR;
    #1;
    assertCount++;
    if (dataBusOut !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL read_with_we: got %h expected 00000000", dataBusOut);
    end
    re = 1'b0;
    we = 1'b0;
    memAddr = '0;
    irqIn = 4'b0000;
    tick(2);
  endtask

  task automatic test_service;
    busWrite(MASK_ADDR, 32'hFFFFFFFF);
    busRead(MASK_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h0000000F) begin
      failCount++;
      $display("[TB] FAIL mask_read: got %h expected 0000000f", rdData);
    end
    @(negedge clk);
    irqIn = 4'b0110;
    tick(1);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL latency_cycle1: got %0b expected 0", intr);
    end
    tick(1);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL latency_cycle2: got %0b expected 1", intr);
    end
    assertCount++;
    if (debug !== 32'h000001FF) begin
      failCount++;
      $display("[TB] FAIL pending_debug: got %h expected 000001ff", debug);
    end
    busRead(PEND_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00060006) begin
      failCount++;
      $display("[TB] FAIL pending_pend: got %h expected 00060006", rdData);
    end
    @(negedge clk);
    intAck = 1'b1;
    irqIn = 4'b0100;
    tick(1);
    intAck = 1'b0;
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ack_intr: got %0b expected 0", intr);
    end
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00000001) begin
      failCount++;
      $display("[TB] FAIL ack_id1: got %h expected 00000001", rdData);
    end
    assertCount++;
    if (debug !== 32'h00000201) begin
      failCount++;
      $display("[TB] FAIL service_debug: got %h expected 00000201", debug);
    end
    @(negedge clk);
    busWrite(EOI_ADDR, 32'h0);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL eoi_intr_now: got %0b expected 0", intr);
    end
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'hFFFFFFFF) begin
      failCount++;
      $display("[TB] FAIL eoi_id: got %h expected ffffffff", rdData);
    end
    tick(1);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL eoi_reenter: got %0b expected 1", intr);
    end
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00000002) begin
      failCount++;
      $display("[TB] FAIL ack_id2: got %h expected 00000002", rdData);
    end
    @(negedge clk);
    irqIn = 4'b0000;
    busWrite(EOI_ADDR, 32'h0);
    tick(1);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL service_done_intr: got %0b expected 0", intr);
    end
  endtask

  task automatic test_withdraw;
    irqIn = 4'b0001;
    tick(2);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL withdraw_raise: got %0b expected 1", intr);
    end
    irqIn = 4'b0000;
    tick(1);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL withdraw_hold: got %0b expected 1", intr);
    end
    tick(1);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL withdraw_drop: got %0b expected 0", intr);
    end
    assertCount++;
    if (debug !== 32'h00000002) begin
      failCount++;
      $display("[TB] FAIL withdraw_debug: got %h expected 00000002", debug);
    end
  endtask

  task automatic test_spurious;
    irqIn = 4'b0001;
    tick(2);
    irqIn = 4'b0000;
    tick(1);
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'hFFFFFFFF) begin
      failCount++;
      $display("[TB] FAIL spurious_id: got %h expected ffffffff", rdData);
    end
    assertCount++;
    if (debug !== 32'h000002FF) begin
      failCount++;
      $display("[TB] FAIL spurious_debug: got %h expected 000002ff", debug);
    end
    @(negedge clk);
    busWrite(EOI_ADDR, 32'h0);
    assertCount++;
    if (debug !== 32'h000000FF) begin
      failCount++;
      $display("[TB] FAIL spurious_eoi_debug: got %h expected 000000ff", debug);
    end
  endtask

  task automatic test_mask_ack;
    irqIn = 4'b1000;
    tick(2);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL maskack_raise: got %0b expected 1", intr);
    end
    intAck = 1'b1;
    busWrite(MASK_ADDR, 32'h0);
    intAck = 1'b0;
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00000003) begin
      failCount++;
      $display("[TB] FAIL maskack_id: got %h expected 00000003", rdData);
    end
    busRead(MASK_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL maskack_mask: got %h expected 00000000", rdData);
    end
    @(negedge clk);
    busWrite(EOI_ADDR, 32'h0);
    tick(1);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL maskack_after_eoi: got %0b expected 0", intr);
    end
    busWrite(MASK_ADDR, 32'h0000000F);
    tick(1);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL masknoack_raise: got %0b expected 1", intr);
    end
    busWrite(MASK_ADDR, 32'h0);
    assertCount++;
    if (intr !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL masknoack_hold: got %0b expected 1", intr);
    end
    tick(1);
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL masknoack_drop: got %0b expected 0", intr);
    end
  endtask

  task automatic test_async_reset;
    irqIn = 4'b0001;
    busWrite(MASK_ADDR, 32'h0000000F);
    tick(1);
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    assertCount++;
    if (debug !== 32'h00000200) begin
      failCount++;
      $display("[TB] FAIL prereset_debug: got %h expected 00000200", debug);
    end
    #2;
    reset = 1'b1;
    #1;
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_intr: got %0b expected 0", intr);
    end
    assertCount++;
    if (debug !== 32'h000000FF) begin
      failCount++;
      $display("[TB] FAIL async_debug: got %h expected 000000ff", debug);
    end
    busRead(MASK_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL async_mask: got %h expected 00000000", rdData);
    end
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'hFFFFFFFF) begin
      failCount++;
      $display("[TB] FAIL async_id: got %h expected ffffffff", rdData);
    end
    irqIn = 4'b0000;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_idle_ignore;
    busWrite(MASK_ADDR, 32'h0000000F);
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    assertCount++;
    if (debug !== 32'h000000FF) begin
      failCount++;
      $display("[TB] FAIL idle_ack_debug: got %h expected 000000ff", debug);
    end
    busWrite(EOI_ADDR, 32'h0);
    assertCount++;
    if (debug !== 32'h000000FF) begin
      failCount++;
      $display("[TB] FAIL idle_eoi_debug: got %h expected 000000ff", debug);
    end
    assertCount++;
    if (intr !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL idle_intr: got %0b expected 0", intr);
    end
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'hFFFFFFFF) begin
      failCount++;
      $display("[TB] FAIL idle_id: got %h expected ffffffff", rdData);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    irqIn = 4'b1010;
    tick(2);
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00000001) begin
      failCount++;
      $display("[TB] FAIL b2b_first_id: got %h expected 00000001", rdData);
    end
    @(negedge clk);
    irqIn = 4'b1000;
    busWrite(EOI_ADDR, 32'h0);
    tick(1);
    intAck = 1'b1;
    tick(1);
    intAck = 1'b0;
    busRead(ID_ADDR, rdData);
    assertCount++;
    if (rdData !== 32'h00000003) begin
      failCount++;
      $display("[TB] FAIL b2b_second_id: got %h expected 00000003", rdData);
    end
    @(negedge clk);
    irqIn = 4'b0000;
    busWrite(EOI_ADDR, 32'h0);
    tick(1);
  endtask

  initial begin
    assertCount = 0;
    failCount = 0;
    reset = 1'b0;
    we = 1'b0;
    re = 1'b0;
    memAddr = '0;
    dataBusIn = '0;
    irqIn = '0;
    intAck = 1'b0;
    test_reset();
    test_masked();
    test_service();
    test_withdraw();
    test_spurious();
    test_mask_ack();
    test_async_reset();
    test_idle_ignore();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
